// File: rtl/vram_bus_sched_pkg.sv
// Shared types and constants for the PPU VRAM bus scheduler.
package vram_bus_sched_pkg;

    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 8;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned PAGE_W = AW - 8;

    localparam logic [PAGE_W-1:0] PAL_PAGE = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OWN_RND = 1'b0,
        OWN_CPU = 1'b1
    } owner_e;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } bus_entry_t;

    // Palette writes are absorbed internally instead of going out on the pads.
    function automatic logic is_pal(input logic [PAGE_W-1:0] page);
        return page == PAL_PAGE;
    endfunction

endpackage

// File: rtl/vram_bus_sched_cpu_req_buf.sv
// One-entry holding register for CPU $2007 accesses with overflow pulse.
module vram_bus_sched_cpu_req_buf
    import vram_bus_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  bus_entry_t din,
    input  logic       free,
    output bus_entry_t q,
    output logic       full,
    output logic       ovf
);

    logic accept_c;

    // A request arriving on the free cycle refills the slot immediately.
    assign accept_c = load && (!full || free);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            full <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            ovf <= load && full && !free;
            if (accept_c) begin
                q    <= din;
                full <= 1'b1;
            end else if (free) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vram_bus_sched.sv
// PPU VRAM bus owner: arbitrates render fetches against CPU accesses and
// sequences each as an address phase then a data phase on registered pads.
module vram_bus_sched
    import vram_bus_sched_pkg::*;
#(
    parameter int unsigned PHASE_CYC = 2
) (
    input  logic          CLK,
    input  logic          n_RES,
    input  logic          rnd_req,
    input  logic [AW-1:0] rnd_addr,
    output logic          rnd_ack,
    output logic [DW-1:0] rnd_rdata,
    output logic          rnd_wait,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ovf,
    output logic          tstep,
    output logic          pal_we,
    input  logic [DW-1:0] ad_in,
    output logic [DW-1:0] ad_out,
    output logic          ad_oe,
    output logic [AW-1:0] pa_out,
    output logic          ale,
    output logic          n_rd,
    output logic          n_wr
);

    state_e           state, state_nxt;
    owner_e           owner, owner_nxt;
    bus_entry_t       cur, cur_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    bus_entry_t cpu_in;
    bus_entry_t buf_q;
    logic       buf_full;

    logic          last_c;
    logic          drive_addr, drive_data, ack_nxt;
    logic          ale_nxt, n_rd_nxt, n_wr_nxt, ad_oe_nxt, pal_we_nxt;
    logic          rnd_ack_nxt, cpu_ack_nxt, rnd_wait_nxt;
    logic [DW-1:0] ad_out_nxt, rnd_rdata_nxt, cpu_rdata_nxt;
    logic [AW-1:0] pa_out_nxt;

    assign cpu_in = {cpu_we, cpu_addr, cpu_wdata};
    assign last_c = (cnt == CNT_W'(PHASE_CYC - 1));

    vram_bus_sched_cpu_req_buf u_cpu_buf (
        .clk   (CLK),
        .rst_n (n_RES),
        .load  (cpu_req),
        .din   (cpu_in),
        .free  (cpu_ack),
        .q     (buf_q),
        .full  (buf_full),
        .ovf   (cpu_ovf)
    );

    // Next-state, phase counter and next pad/strobe values.
    always_comb begin
        state_nxt     = state;
        owner_nxt     = owner;
        cur_nxt       = cur;
        cnt_nxt       = cnt;
        drive_addr    = 1'b0;
        drive_data    = 1'b0;
        ack_nxt       = 1'b0;
        pal_we_nxt    = 1'b0;
        rnd_rdata_nxt = rnd_rdata;
        cpu_rdata_nxt = cpu_rdata;

        case (state)
            ST_IDLE: begin
                // Render always wins; a fresh cpu_req is granted straight from the inputs.
                if (rnd_req) begin
                    state_nxt  = ST_ADDR;
                    cnt_nxt    = '0;
                    owner_nxt  = OWN_RND;
                    cur_nxt    = {1'b0, rnd_addr, DW'(0)};
                    drive_addr = 1'b1;
                end else if (buf_full || cpu_req) begin
                    state_nxt  = ST_ADDR;
                    cnt_nxt    = '0;
                    owner_nxt  = OWN_CPU;
                    cur_nxt    = buf_full ? buf_q : cpu_in;
                    drive_addr = 1'b1;
                end
            end
            ST_ADDR: begin
                if (last_c) begin
                    state_nxt  = ST_DATA;
                    cnt_nxt    = '0;
                    drive_data = 1'b1;
                    pal_we_nxt = cur.we && is_pal(cur.addr[AW-1:8]);
                end else begin
                    cnt_nxt    = cnt + CNT_W'(1);
                    drive_addr = 1'b1;
                end
            end
            ST_DATA: begin
                if (last_c) begin
                    state_nxt = ST_DONE;
                    ack_nxt   = 1'b1;
                    if (!cur.we) begin
                        if (owner == OWN_RND) rnd_rdata_nxt = ad_in;
                        else                  cpu_rdata_nxt = ad_in;
                    end
                end else begin
                    cnt_nxt    = cnt + CNT_W'(1);
                    drive_data = 1'b1;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase

        ale_nxt    = drive_addr;
        ad_oe_nxt  = 1'b0;
        ad_out_nxt = ad_out;
        pa_out_nxt = pa_out;
        n_rd_nxt   = 1'b1;
        n_wr_nxt   = 1'b1;

        if (drive_addr) begin
            ad_oe_nxt  = 1'b1;
            ad_out_nxt = cur_nxt.addr[7:0];
            pa_out_nxt = cur_nxt.addr;
        end

        if (drive_data) begin
            if (!cur.we) begin
                n_rd_nxt = 1'b0;
            end else if (!is_pal(cur.addr[AW-1:8])) begin
                ad_oe_nxt  = 1'b1;
                ad_out_nxt = cur.wdata;
                n_wr_nxt   = 1'b0;
            end
        end

        rnd_ack_nxt  = ack_nxt && (owner == OWN_RND);
        cpu_ack_nxt  = ack_nxt && (owner == OWN_CPU);
        rnd_wait_nxt = rnd_req && (state_nxt != ST_IDLE) && (owner_nxt == OWN_CPU);
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            state     <= ST_IDLE;
            owner     <= OWN_RND;
            cur       <= '0;
            cnt       <= '0;
            ale       <= 1'b0;
            n_rd      <= 1'b1;
            n_wr      <= 1'b1;
            ad_oe     <= 1'b0;
            ad_out    <= '0;
            pa_out    <= '0;
            pal_we    <= 1'b0;
            rnd_ack   <= 1'b0;
            cpu_ack   <= 1'b0;
            tstep     <= 1'b0;
            rnd_wait  <= 1'b0;
            rnd_rdata <= '0;
            cpu_rdata <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            cur       <= cur_nxt;
            cnt       <= cnt_nxt;
            ale       <= ale_nxt;
            n_rd      <= n_rd_nxt;
            n_wr      <= n_wr_nxt;
            ad_oe     <= ad_oe_nxt;
            ad_out    <= ad_out_nxt;
            pa_out    <= pa_out_nxt;
            pal_we    <= pal_we_nxt;
            rnd_ack   <= rnd_ack_nxt;
            cpu_ack   <= cpu_ack_nxt;
            tstep     <= cpu_ack_nxt;
            rnd_wait  <= rnd_wait_nxt;
            rnd_rdata <= rnd_rdata_nxt;
            cpu_rdata <= cpu_rdata_nxt;
        end
    end

endmodule
